// File: rtl/rob_commit_ctrl.sv
// Reorder-buffer sequencing controller: in-order allocate at the tail, out-of-order
// completion by index, in-order single retire from the head, and a full-buffer flush.
module rob_commit_ctrl #(
    parameter int DEPTH  = 32,
    parameter int IDX_W  = 5,
    parameter int PREG_W = 6,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              alloc_valid,
    output logic              alloc_ready,
    output logic [IDX_W-1:0]  alloc_idx,
    input  logic [PREG_W-1:0] alloc_old_preg,
    input  logic [PREG_W-1:0] alloc_new_preg,
    input  logic [6:0]        alloc_opcode,
    input  logic              cmpl_valid,
    input  logic [IDX_W-1:0]  cmpl_idx,
    input  logic [DATA_W-1:0] cmpl_value,
    input  logic [DATA_W-1:0] cmpl_rs2_value,
    input  logic              flush,
    output logic              retire_valid,
    output logic [IDX_W-1:0]  retire_idx,
    output logic [PREG_W-1:0] retire_preg,
    output logic [PREG_W-1:0] retire_free_preg,
    output logic [6:0]        retire_opcode,
    output logic [DATA_W-1:0] retire_value,
    output logic [DATA_W-1:0] retire_rs2_value,
    output logic [IDX_W:0]    count
);

    localparam logic [IDX_W:0] FULL_COUNT = (IDX_W + 1)'(DEPTH);

    logic [IDX_W-1:0]  head_q;
    logic [IDX_W-1:0]  tail_q;
    logic [IDX_W:0]    count_q;
    logic [DEPTH-1:0]  in_use_q;
    logic [DEPTH-1:0]  complete_q;
    logic [PREG_W-1:0] old_preg_q  [DEPTH];
    logic [PREG_W-1:0] curr_preg_q [DEPTH];
    logic [6:0]        opcode_q    [DEPTH];
    logic [DATA_W-1:0] value_q     [DEPTH];
    logic [DATA_W-1:0] rs2_value_q [DEPTH];

    logic alloc_fire;
    logic cmpl_fire;
    logic retire_fire;
    logic cmpl_hits_retiring;

    // Handshake: an allocation happens on a rising edge where alloc_valid && alloc_ready;
    // alloc_ready depends only on registered count, never on this cycle's retire.
    assign alloc_ready        = (count_q < FULL_COUNT);
    assign alloc_idx          = tail_q;
    assign count              = count_q;
    assign alloc_fire         = alloc_valid && alloc_ready;
    assign cmpl_fire          = cmpl_valid && in_use_q[cmpl_idx];
    assign retire_fire        = in_use_q[head_q] && complete_q[head_q];
    assign cmpl_hits_retiring = retire_fire && (cmpl_idx == head_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (flush) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (alloc_fire) tail_q <= tail_q + 1'b1;
            if (retire_fire) head_q <= head_q + 1'b1;
            case ({alloc_fire, retire_fire})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // The retiring entry's clear wins over a late completion aimed at the same slot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_use_q   <= '0;
            complete_q <= '0;
        end else if (flush) begin
            in_use_q   <= '0;
            complete_q <= '0;
        end else begin
            if (retire_fire) begin
                in_use_q[head_q]   <= 1'b0;
                complete_q[head_q] <= 1'b0;
            end
            if (cmpl_fire && !cmpl_hits_retiring) complete_q[cmpl_idx] <= 1'b1;
            if (alloc_fire) begin
                in_use_q[tail_q]   <= 1'b1;
                complete_q[tail_q] <= 1'b0;
            end
        end
    end

    // Payload storage is only meaningful while the flags mark it valid, so it needs no reset.
    always_ff @(posedge clk) begin
        if (!flush) begin
            if (alloc_fire) begin
                old_preg_q[tail_q]  <= alloc_old_preg;
                curr_preg_q[tail_q] <= alloc_new_preg;
                opcode_q[tail_q]    <= alloc_opcode;
            end
            if (cmpl_fire) begin
                value_q[cmpl_idx]     <= cmpl_value;
                rs2_value_q[cmpl_idx] <= cmpl_rs2_value;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retire_valid     <= 1'b0;
            retire_idx       <= '0;
            retire_preg      <= '0;
            retire_free_preg <= '0;
            retire_opcode    <= '0;
            retire_value     <= '0;
            retire_rs2_value <= '0;
        end else if (flush) begin
            retire_valid <= 1'b0;
        end else if (retire_fire) begin
            retire_valid     <= 1'b1;
            retire_idx       <= head_q;
            retire_preg      <= curr_preg_q[head_q];
            retire_free_preg <= old_preg_q[head_q];
            retire_opcode    <= opcode_q[head_q];
            retire_value     <= value_q[head_q];
            retire_rs2_value <= rs2_value_q[head_q];
        end else begin
            retire_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rob_commit_ctrl.sv
// Directed bench for rob_commit_ctrl: a table of per-cycle vectors with hand-computed
// expectations, plus hand-written fill/wrap and asynchronous-reset sequences.
module tb_rob_commit_ctrl;

    logic        clk;
    logic        reset;
    logic        alloc_valid;
    logic        alloc_ready;
    logic [4:0]  alloc_idx;
    logic [5:0]  alloc_old_preg;
    logic [5:0]  alloc_new_preg;
    logic [6:0]  alloc_opcode;
    logic        cmpl_valid;
    logic [4:0]  cmpl_idx;
    logic [31:0] cmpl_value;
    logic [31:0] cmpl_rs2_value;
    logic        flush;
    logic        retire_valid;
    logic [4:0]  retire_idx;
    logic [5:0]  retire_preg;
    logic [5:0]  retire_free_preg;
    logic [6:0]  retire_opcode;
    logic [31:0] retire_value;
    logic [31:0] retire_rs2_value;
    logic [5:0]  count;

    int checks;
    int failures;

    rob_commit_ctrl dut (
        .clk(clk), .reset(reset),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_idx(alloc_idx),
        .alloc_old_preg(alloc_old_preg), .alloc_new_preg(alloc_new_preg),
        .alloc_opcode(alloc_opcode),
        .cmpl_valid(cmpl_valid), .cmpl_idx(cmpl_idx), .cmpl_value(cmpl_value),
        .cmpl_rs2_value(cmpl_rs2_value), .flush(flush),
        .retire_valid(retire_valid), .retire_idx(retire_idx), .retire_preg(retire_preg),
        .retire_free_preg(retire_free_preg), .retire_opcode(retire_opcode),
        .retire_value(retire_value), .retire_rs2_value(retire_rs2_value), .count(count)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        av;
        logic [5:0]  old_p;
        logic [5:0]  new_p;
        logic [6:0]  op;
        logic        cv;
        logic [4:0]  ci;
        logic [31:0] val;
        logic [31:0] rs2;
        logic        fl;
        logic [5:0]  e_cnt;
        logic [4:0]  e_ai;
        logic        e_rv;
        logic [4:0]  e_ridx;
        logic [5:0]  e_preg;
        logic [5:0]  e_free;
        logic [6:0]  e_op;
        logic [31:0] e_val;
        logic [31:0] e_rs2;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic set_idle();
        alloc_valid    = 1'b0;
        alloc_old_preg = '0;
        alloc_new_preg = '0;
        alloc_opcode   = '0;
        cmpl_valid     = 1'b0;
        cmpl_idx       = '0;
        cmpl_value     = '0;
        cmpl_rs2_value = '0;
        flush          = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        set_idle();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
    endtask

    task automatic drive_alloc(input logic [5:0] o, input logic [5:0] n, input logic [6:0] op);
        alloc_valid    = 1'b1;
        alloc_old_preg = o;
        alloc_new_preg = n;
        alloc_opcode   = op;
    endtask

    task automatic drive_cmpl(input logic [4:0] idx, input logic [31:0] v, input logic [31:0] r);
        cmpl_valid     = 1'b1;
        cmpl_idx       = idx;
        cmpl_value     = v;
        cmpl_rs2_value = r;
    endtask

    // Row builder: inputs first, then the expected post-edge outputs.
    function automatic vec_t mk(
        input logic av, input logic [5:0] o, input logic [5:0] n, input logic [6:0] op,
        input logic cv, input logic [4:0] ci, input logic [31:0] v, input logic [31:0] r,
        input logic fl, input logic [5:0] e_cnt, input logic [4:0] e_ai, input logic e_rv,
        input logic [4:0] e_ridx, input logic [5:0] e_preg, input logic [5:0] e_free,
        input logic [6:0] e_op, input logic [31:0] e_val, input logic [31:0] e_rs2);
        vec_t t;
        t.av = av; t.old_p = o; t.new_p = n; t.op = op;
        t.cv = cv; t.ci = ci; t.val = v; t.rs2 = r; t.fl = fl;
        t.e_cnt = e_cnt; t.e_ai = e_ai; t.e_rv = e_rv; t.e_ridx = e_ridx;
        t.e_preg = e_preg; t.e_free = e_free; t.e_op = e_op; t.e_val = e_val; t.e_rs2 = e_rs2;
        return t;
    endfunction

    initial begin
        checks   = 0;
        failures = 0;
        set_idle();

        // Test 1: reset state
        do_reset();
        chk("reset_alloc_ready", 32'(alloc_ready), 32'd1);
        chk("reset_count", 32'(count), 32'd0);
        chk("reset_alloc_idx", 32'(alloc_idx), 32'd0);
        chk("reset_retire_valid", 32'(retire_valid), 32'd0);
        chk("reset_retire_value", retire_value, 32'd0);

        // Test 2: three ordered ops with out-of-order completion
        vecs.push_back(mk(1, 1, 33, 7'h21, 0, 0, 0, 0, 0,  1, 1, 0, 0, 0, 0, 7'h00, 32'h0, 32'h0));
        vecs.push_back(mk(1, 2, 34, 7'h22, 0, 0, 0, 0, 0,  2, 2, 0, 0, 0, 0, 7'h00, 32'h0, 32'h0));
        vecs.push_back(mk(1, 3, 35, 7'h23, 0, 0, 0, 0, 0,  3, 3, 0, 0, 0, 0, 7'h00, 32'h0, 32'h0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 2, 32'hC, 32'hD, 0, 3, 3, 0, 0, 0, 0, 7'h00, 32'h0, 32'h0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 32'hA, 32'hB, 0, 3, 3, 0, 0, 0, 0, 7'h00, 32'h0, 32'h0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 1, 32'hB, 32'hC, 0, 2, 3, 1, 0, 33, 1, 7'h21, 32'hA, 32'hB));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,       1, 3, 1, 1, 34, 2, 7'h22, 32'hB, 32'hC));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,       0, 3, 1, 2, 35, 3, 7'h23, 32'hC, 32'hD));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,       0, 3, 0, 2, 35, 3, 7'h23, 32'hC, 32'hD));
        // Test 4: build count=5 then allocate while the head retires
        vecs.push_back(mk(1, 10, 40, 7'h2A, 0, 0, 0, 0, 0, 1, 4, 0, 2, 35, 3, 7'h23, 32'hC, 32'hD));
        vecs.push_back(mk(1, 11, 41, 7'h2B, 0, 0, 0, 0, 0, 2, 5, 0, 2, 35, 3, 7'h23, 32'hC, 32'hD));
        vecs.push_back(mk(1, 12, 42, 7'h2C, 0, 0, 0, 0, 0, 3, 6, 0, 2, 35, 3, 7'h23, 32'hC, 32'hD));
        vecs.push_back(mk(1, 13, 43, 7'h2D, 0, 0, 0, 0, 0, 4, 7, 0, 2, 35, 3, 7'h23, 32'hC, 32'hD));
        vecs.push_back(mk(1, 14, 44, 7'h2E, 0, 0, 0, 0, 0, 5, 8, 0, 2, 35, 3, 7'h23, 32'hC, 32'hD));
        vecs.push_back(mk(0, 0, 0, 0, 1, 3, 32'h300, 32'h301, 0, 5, 8, 0, 2, 35, 3, 7'h23, 32'hC, 32'hD));
        vecs.push_back(mk(1, 15, 45, 7'h2F, 0, 0, 0, 0, 0, 5, 9, 1, 3, 40, 10, 7'h2A, 32'h300, 32'h301));
        vecs.push_back(mk(0, 0, 0, 0, 1, 4, 32'h400, 32'h401, 0, 5, 9, 0, 3, 40, 10, 7'h2A, 32'h300, 32'h301));
        vecs.push_back(mk(0, 0, 0, 0, 1, 5, 32'h500, 32'h501, 0, 4, 9, 1, 4, 41, 11, 7'h2B, 32'h400, 32'h401));
        // Test 5: flush at count=4 with alloc and head completion pending -> all discarded
        vecs.push_back(mk(1, 16, 46, 7'h30, 1, 5, 32'h555, 32'h556, 1, 0, 0, 0, 4, 41, 11, 7'h2B, 32'h400, 32'h401));
        vecs.push_back(mk(0, 0, 0, 0, 1, 1, 32'hDEAD, 32'hBEEF, 0, 0, 0, 0, 4, 41, 11, 7'h2B, 32'h400, 32'h401));
        vecs.push_back(mk(1, 20, 50, 7'h34, 0, 0, 0, 0, 0, 1, 1, 0, 4, 41, 11, 7'h2B, 32'h400, 32'h401));
        vecs.push_back(mk(1, 21, 51, 7'h35, 0, 0, 0, 0, 0, 2, 2, 0, 4, 41, 11, 7'h2B, 32'h400, 32'h401));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 32'h600, 32'h601, 0, 2, 2, 0, 4, 41, 11, 7'h2B, 32'h400, 32'h401));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,        1, 2, 1, 0, 50, 20, 7'h34, 32'h600, 32'h601));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,        1, 2, 0, 0, 50, 20, 7'h34, 32'h600, 32'h601));

        foreach (vecs[i]) begin
            alloc_valid    = vecs[i].av;
            alloc_old_preg = vecs[i].old_p;
            alloc_new_preg = vecs[i].new_p;
            alloc_opcode   = vecs[i].op;
            cmpl_valid     = vecs[i].cv;
            cmpl_idx       = vecs[i].ci;
            cmpl_value     = vecs[i].val;
            cmpl_rs2_value = vecs[i].rs2;
            flush          = vecs[i].fl;
            tick();
            chk($sformatf("v%0d_count", i), 32'(count), 32'(vecs[i].e_cnt));
            chk($sformatf("v%0d_alloc_idx", i), 32'(alloc_idx), 32'(vecs[i].e_ai));
            chk($sformatf("v%0d_alloc_ready", i), 32'(alloc_ready), 32'd1);
            chk($sformatf("v%0d_retire_valid", i), 32'(retire_valid), 32'(vecs[i].e_rv));
            chk($sformatf("v%0d_retire_idx", i), 32'(retire_idx), 32'(vecs[i].e_ridx));
            chk($sformatf("v%0d_retire_preg", i), 32'(retire_preg), 32'(vecs[i].e_preg));
            chk($sformatf("v%0d_retire_free", i), 32'(retire_free_preg), 32'(vecs[i].e_free));
            chk($sformatf("v%0d_retire_op", i), 32'(retire_opcode), 32'(vecs[i].e_op));
            chk($sformatf("v%0d_retire_value", i), retire_value, vecs[i].e_val);
            chk($sformatf("v%0d_retire_rs2", i), retire_rs2_value, vecs[i].e_rs2);
            @(negedge clk);
        end
        set_idle();

        // Test 3: fill, overflow attempt, retire from full, wrap
        do_reset();
        for (int i = 0; i < 32; i++) begin
            drive_alloc(6'(i), 6'(i + 32), 7'(i));
            tick();
            @(negedge clk);
        end
        set_idle();
        chk("fill_count", 32'(count), 32'd32);
        chk("fill_alloc_ready", 32'(alloc_ready), 32'd0);
        chk("fill_alloc_idx", 32'(alloc_idx), 32'd0);
        drive_alloc(6'd63, 6'd62, 7'h7F);
        tick();
        chk("overflow_count", 32'(count), 32'd32);
        chk("overflow_alloc_idx", 32'(alloc_idx), 32'd0);
        @(negedge clk);
        set_idle();
        drive_cmpl(5'd0, 32'h777, 32'h778);
        tick();
        chk("full_cmpl_count", 32'(count), 32'd32);
        chk("full_cmpl_rv", 32'(retire_valid), 32'd0);
        @(negedge clk);
        set_idle();
        drive_alloc(6'd40, 6'd41, 7'h11);
        chk("retire_cycle_alloc_ready", 32'(alloc_ready), 32'd0);
        tick();
        chk("full_retire_rv", 32'(retire_valid), 32'd1);
        chk("full_retire_idx", 32'(retire_idx), 32'd0);
        chk("full_retire_free", 32'(retire_free_preg), 32'd0);
        chk("full_retire_preg", 32'(retire_preg), 32'd32);
        chk("full_retire_value", retire_value, 32'h777);
        chk("full_retire_count", 32'(count), 32'd31);
        chk("post_retire_alloc_ready", 32'(alloc_ready), 32'd1);
        @(negedge clk);
        set_idle();
        drive_alloc(6'd40, 6'd41, 7'h11);
        chk("wrap_alloc_idx_pre", 32'(alloc_idx), 32'd0);
        tick();
        chk("wrap_count", 32'(count), 32'd32);
        chk("wrap_alloc_idx_post", 32'(alloc_idx), 32'd1);
        chk("wrap_alloc_ready", 32'(alloc_ready), 32'd0);
        @(negedge clk);
        set_idle();

        // Test 6: asynchronous reset with a retire pending
        do_reset();
        @(negedge clk);
        drive_alloc(6'd5, 6'd45, 7'h03);
        tick(); @(negedge clk);
        drive_alloc(6'd6, 6'd46, 7'h04);
        tick(); @(negedge clk);
        set_idle();
        drive_cmpl(5'd0, 32'h900, 32'h901);
        tick(); @(negedge clk);
        drive_cmpl(5'd1, 32'h910, 32'h911);
        tick();
        chk("pre_areset_rv", 32'(retire_valid), 32'd1);
        chk("pre_areset_count", 32'(count), 32'd1);
        @(negedge clk);
        set_idle();
        #2;
        reset = 1'b1;
        #1;
        chk("areset_rv", 32'(retire_valid), 32'd0);
        chk("areset_count", 32'(count), 32'd0);
        chk("areset_alloc_idx", 32'(alloc_idx), 32'd0);
        chk("areset_alloc_ready", 32'(alloc_ready), 32'd1);
        chk("areset_retire_value", retire_value, 32'd0);
        chk("areset_retire_free", 32'(retire_free_preg), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        tick();
        chk("post_areset_rv", 32'(retire_valid), 32'd0);
        chk("post_areset_count", 32'(count), 32'd0);
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rob_commit_ctrl.md
Name: rob_commit_ctrl

Overview:
- Sequencing controller for the 32-entry reorder buffer (rob_entry array).
- Allocates entries in program order at the tail and records completion results by index.
- Retires completed entries in order from the head, at most one per cycle.
- Returns the superseded physical register (old_d_reg) to the free list and supports a full-buffer flush.

Parameters:
- DEPTH, 32, number of ROB entries; power of two.
- IDX_W, 5, log2(DEPTH); width of ROB index and pointers.
- PREG_W, 6, physical register tag width.
- DATA_W, 32, result value width.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- alloc_valid  in  1  dispatch requests an entry this cycle.
- alloc_ready  out  1  high when count < DEPTH.
- alloc_idx  out  IDX_W  current tail index; this is the index the allocation receives.
- alloc_old_preg  in  PREG_W  previous mapping of the destination register.
- alloc_new_preg  in  PREG_W  newly assigned destination physical register.
- alloc_opcode  in  7  instruction opcode.
- cmpl_valid  in  1  a functional unit reports completion.
- cmpl_idx  in  IDX_W  ROB index being completed.
- cmpl_value  in  DATA_W  result value.
- cmpl_rs2_value  in  DATA_W  store data (rs2_value).
- flush  in  1  synchronous squash of all entries.
- retire_valid  out  1  registered; one-cycle pulse per retired entry.
- retire_idx  out  IDX_W  index of the retired entry.
- retire_preg  out  PREG_W  curr_d_reg of the retired entry.
- retire_free_preg  out  PREG_W  old_d_reg of the retired entry, sent to the free list.
- retire_opcode  out  7  rd_opcode of the retired entry.
- retire_value  out  DATA_W  rd_value of the retired entry.
- retire_rs2_value  out  DATA_W  rs2_value of the retired entry.
- count  out  IDX_W+1  number of occupied entries, 0..DEPTH.

Behaviour:
- Reset (async):
  - head = tail = 0, count = 0.
  - Every entry: in_use = 0, is_complete = 0.
  - All retire_* outputs = 0; alloc_ready = 1.
- Allocate (alloc_valid && alloc_ready):
  - At the edge, entry[tail] gets in_use = 1, is_complete = 0, old/curr preg and opcode.
  - tail increments, wrapping 31 -> 0.
  - alloc_valid while full is ignored; no state change.
- Complete (cmpl_valid && entry[cmpl_idx].in_use):
  - At the edge, entry gets is_complete = 1, rd_value and rs2_value.
  - Completion to an entry that is not in use is ignored.
  - Completion to an already-complete entry overwrites the values.
- Retire:
  - Fires when entry[head].in_use && entry[head].is_complete, evaluated on registered state.
  - At the edge: retire_* are loaded from entry[head], retire_valid = 1, the entry is cleared (in_use = 0, is_complete = 0), and head increments with wrap.
  - In all other cycles retire_valid = 0 and the other retire_* outputs hold their last values.
  - Latency: completion captured at edge N; earliest retire_valid is after edge N+1. There is no same-cycle bypass.
- count: +1 on allocate, −1 on retire, unchanged when both occur in the same cycle.
- alloc_ready is derived from registered count only. Retiring from a full buffer does not enable allocation in that same cycle.
- Simultaneous allocate and completion of different indices: both take effect.
- Flush:
  - Highest priority; at the edge, allocate, complete and retire that cycle are discarded.
  - All entries cleared, head = tail = count = 0, retire_valid = 0.
- Reset mid-operation: immediate return to the reset state; in-flight entries are lost and nothing is retired.
- Full: count == DEPTH, with head == tail. Empty: count == 0, with head == tail. Full vs empty is distinguished by count, never by pointer compare.

Test Plan:
1. Assert reset, then release -> alloc_ready=1, count=0, alloc_idx=0, retire_valid=0.
2. Three ordered operations:
   - Stimulus: allocate 3 entries (old 1/2/3, new 33/34/35); complete idx 2 (value 0xC), then idx 0 (0xA), then idx 1 (0xB) in successive cycles.
   - Response: retires idx 0, 1, 2 in order; values 0xA, 0xB, 0xC; retire_free_preg 1, 2, 3; count returns to 0.
3. Fill and wrap:
   - Stimulus: 32 allocations; then a 33rd alloc_valid; then complete and retire idx 0; then allocate again.
   - Response: after 32 allocations count=32, alloc_ready=0, and the 33rd is ignored. After the retire, count=31, with alloc_ready=1 one cycle after the retire edge. The next allocation receives alloc_idx=0, confirming tail wrap.
4. Steady state:
   - Stimulus: at count=5 with the head complete, allocate in the same cycle.
   - Response: count stays 5, retire_valid=1, tail and head each advance by 1.
5. Flush:
   - Stimulus: with count=4, pulse flush together with alloc_valid and cmpl_valid on the head.
   - Response: next cycle count=0, alloc_idx=0, no retire_valid.
   - Stimulus: a later completion to idx 1.
   - Response: ignored, since the entry is not in use.
6. Async reset:
   - Stimulus: assert reset mid-cycle while retire is pending.
   - Response: outputs clear immediately without waiting for a clock edge; retire_valid=0 and count=0.
